// File: rtl/scroll_code_sequencer_if.sv
// Symbol-code write port, scroll control and per-digit display outputs of the scroll sequencer.
// Latency: none, this is just wiring.
// Backpressure: the writer holds wr_valid_i, wr_code_i and wr_last_i until wr_ready_o is seen high.
// Ports: master = message source / controller, slave = scroll_code_sequencer.
//   wr_valid_i/wr_code_i/wr_last_i/wr_ready_o : symbol append handshake
//   start_i/stop_i                            : scroll control
//   busy_o/done_o/code_o/blank_o              : status and display window
interface scroll_code_sequencer_if #(
   parameter int N_DIGITS = 6
);
   logic                    wr_valid_i;
   logic [2:0]              wr_code_i;
   logic                    wr_last_i;
   logic                    wr_ready_o;
   logic                    start_i;
   logic                    stop_i;
   logic                    busy_o;
   logic                    done_o;
   logic [3*N_DIGITS-1:0]   code_o;
   logic [N_DIGITS-1:0]     blank_o;

   modport master (
      output wr_valid_i, wr_code_i, wr_last_i, start_i, stop_i,
      input  wr_ready_o, busy_o, done_o, code_o, blank_o
   );

   modport slave (
      input  wr_valid_i, wr_code_i, wr_last_i, start_i, stop_i,
      output wr_ready_o, busy_o, done_o, code_o, blank_o
   );
endinterface

// File: rtl/scroll_code_sequencer.sv
// Buffers a message of 3-bit symbol codes and scrolls it right-to-left across N_DIGITS displays.
// Latency: all outputs registered; a new window shows in the cycle after the edge that moves it.
// Backpressure: wr_ready_o is low while scrolling, after a closing symbol, or with a full buffer.
// Ports: clk_i, rst_n_i (async active-low) plus the slave modport of scroll_code_sequencer_if.
//   code_o[3d+2:3d] / blank_o[d] describe digit d, digit 0 being the rightmost display.
module scroll_code_sequencer #(
   parameter int N_DIGITS = 6,
   parameter int DEPTH    = 16,
   parameter int TICK_DIV = 25_000_000
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   scroll_code_sequencer_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH + N_DIGITS + 1);
   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic {IDLE, SCROLL} state_t;

   state_t                  state_q, state_nxt;
   logic [CW-1:0]           count_q, count_nxt;
   logic                    closed_q, closed_nxt;
   logic [PW-1:0]           p_q, p_nxt;
   logic [TW-1:0]           tick_q, tick_nxt;
   logic                    done_nxt;
   logic                    wr_en;
   logic [PW-1:0]           end_pos;

   logic                    wr_ready_q, wr_ready_nxt;
   logic                    busy_q, done_q;
   logic [3*N_DIGITS-1:0]   code_q, code_nxt;
   logic [N_DIGITS-1:0]     blank_q, blank_nxt;
   // One sign bit plus one guard bit so p-1-d never aliases into the valid index range.
   logic [PW+1:0]           idx;

   logic [2:0]              mem_q [DEPTH];

   // wr_ready_q already encodes "idle, open and not full", so it alone qualifies a write.
   assign wr_en   = bus.wr_valid_i && wr_ready_q;
   // Position at which the last symbol has slid off the leftmost digit.
   assign end_pos = PW'(count_q) + PW'(N_DIGITS);

   always_comb begin
      state_nxt  = state_q;
      count_nxt  = count_q;
      closed_nxt = closed_q;
      p_nxt      = p_q;
      tick_nxt   = tick_q;
      done_nxt   = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_en) begin
               count_nxt  = count_q + CW'(1);
               closed_nxt = closed_q | bus.wr_last_i;
            end
            // Start is judged on the count before any same-cycle write.
            if (bus.start_i && (count_q != '0)) begin
               state_nxt = SCROLL;
               p_nxt     = '0;
               tick_nxt  = '0;
            end
         end
         SCROLL: begin
            if (bus.stop_i) begin
               // Abort keeps the message so a later start replays it from the beginning.
               state_nxt = IDLE;
               p_nxt     = '0;
               tick_nxt  = '0;
            end else if (tick_q == TW'(TICK_DIV - 1)) begin
               tick_nxt = '0;
               if (p_q + PW'(1) == end_pos) begin
                  state_nxt  = IDLE;
                  done_nxt   = 1'b1;
                  count_nxt  = '0;
                  closed_nxt = 1'b0;
                  p_nxt      = '0;
               end else begin
                  p_nxt = p_q + PW'(1);
               end
            end else begin
               tick_nxt = tick_q + TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_ready_nxt = (state_nxt == IDLE) && !closed_nxt && (count_nxt < CW'(DEPTH));

   // Window is built from next-state values so the registered outputs track p without extra lag.
   // The buffer is only written in IDLE, where p_nxt is 0 and every digit is blank anyway.
   always_comb begin
      code_nxt  = '0;
      blank_nxt = '1;
      idx       = '0;
      for (int d = 0; d < N_DIGITS; d++) begin
         idx = {2'b00, p_nxt} - (PW+2)'(d + 1);
         if (!idx[PW+1] && (idx[PW:0] < {{(PW+1-CW){1'b0}}, count_nxt})) begin
            code_nxt[3*d +: 3] = mem_q[idx[AW-1:0]];
            blank_nxt[d]       = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         count_q    <= '0;
         closed_q   <= 1'b0;
         p_q        <= '0;
         tick_q     <= '0;
         wr_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         code_q     <= '0;
         blank_q    <= '1;
      end else begin
         state_q    <= state_nxt;
         count_q    <= count_nxt;
         closed_q   <= closed_nxt;
         p_q        <= p_nxt;
         tick_q     <= tick_nxt;
         wr_ready_q <= wr_ready_nxt;
         busy_q     <= (state_nxt == SCROLL);
         done_q     <= done_nxt;
         code_q     <= code_nxt;
         blank_q    <= blank_nxt;
      end
   end

   // Message storage needs no reset: only entries below count are ever displayed.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[count_q[AW-1:0]] <= bus.wr_code_i;
      end
   end

   assign bus.wr_ready_o = wr_ready_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.code_o     = code_q;
   assign bus.blank_o    = blank_q;

endmodule

// File: tb/tb_scroll_code_sequencer.sv
// Randomized scoreboard bench for scroll_code_sequencer (TICK_DIV=4, N_DIGITS=6, DEPTH=16).
// Expected display snapshots are queued when a scroll is launched; a monitor pops one per output change.
// The reference model holds the message as a queue and derives each window from its position.
module tb_scroll_code_sequencer;
   localparam int N = 6;
   localparam int D = 16;
   localparam int T = 4;

   typedef struct {
      int               cyc;
      logic [3*N-1:0]   code;
      logic [N-1:0]     blank;
      logic             busy;
      logic             done;
      logic             rdy;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   scroll_code_sequencer_if #(.N_DIGITS(N)) bus();

   scroll_code_sequencer #(.N_DIGITS(N), .DEPTH(D), .TICK_DIV(T)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   ev_t        exq[$];
   logic [2:0] msg[$];
   bit         closed = 1'b0;
   bit         mon_en = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic bit model_rdy();
      return !closed && (msg.size() < D);
   endfunction

   // Symbol i of the message sits i positions behind the leading edge p.
   function automatic ev_t mk(input int c, input int p, input bit busy, input bit done, input bit rdy);
      ev_t e;
      e.cyc = c; e.busy = busy; e.done = done; e.rdy = rdy;
      e.code = '0; e.blank = '1;
      for (int d = 0; d < N; d++) begin
         int i;
         i = p - 1 - d;
         if (i >= 0 && i < msg.size()) begin
            e.code[3*d +: 3] = msg[i];
            e.blank[d] = 1'b0;
         end
      end
      return e;
   endfunction

   // Monitor: every change of the display/status outputs must match the next queued snapshot.
   initial begin
      logic [4*N+1:0] prev, cur;
      ev_t e;
      prev = {{(3*N){1'b0}}, {N{1'b1}}, 2'b00};
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur = {bus.code_o, bus.blank_o, bus.busy_o, bus.done_o};
            if (cur !== prev) begin
               if (exq.size() == 0) begin
                  check("unexpected_change", 64'(cur), 64'(prev));
               end else begin
                  e = exq.pop_front();
                  check("event_cycle", 64'(cyc), 64'(e.cyc));
                  check("event_outputs", 64'({cur, bus.wr_ready_o}),
                        64'({e.code, e.blank, e.busy, e.done, e.rdy}));
               end
               prev = cur;
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_code"},  64'(bus.code_o), 64'(0));
      check({tag, "_blank"}, 64'(bus.blank_o), 64'({N{1'b1}}));
      check({tag, "_ready"}, 64'(bus.wr_ready_o), 64'(1));
      check({tag, "_busy"},  64'(bus.busy_o), 64'(0));
      check({tag, "_done"},  64'(bus.done_o), 64'(0));
   endtask

   task automatic write_sym(input logic [2:0] c, input bit last, input int hold);
      bit r;
      @(negedge clk);
      bus.wr_valid_i = 1'b1; bus.wr_code_i = c; bus.wr_last_i = last;
      for (int i = 0; i < hold; i++) begin
         r = model_rdy();
         check("wr_ready", 64'(bus.wr_ready_o), 64'(r));
         @(negedge clk);
         if (r) begin
            msg.push_back(c);
            if (last) closed = 1'b1;
            break;
         end
      end
      bus.wr_valid_i = 1'b0; bus.wr_last_i = 1'b0;
   endtask

   // stop_s > 0: stop on the tick that would move p from stop_s to stop_s+1.
   // rst_p > 0: pulse async reset just after position rst_p becomes visible.
   task automatic do_scroll(input int stop_s, input int rst_p);
      int n, k, last_p, stop_cyc, rst_cyc, budget;
      bit did_rst;
      n = msg.size();
      did_rst = 1'b0;
      @(negedge clk);
      bus.start_i = 1'b1;
      k = cyc + 1;
      last_p = (stop_s > 0) ? stop_s : ((rst_p > 0) ? rst_p : n + N - 1);
      exq.push_back(mk(k, 0, 1'b1, 1'b0, 1'b0));
      for (int j = 1; j <= last_p; j++) exq.push_back(mk(k + j*T, j, 1'b1, 1'b0, 1'b0));
      if (stop_s > 0) begin
         exq.push_back(mk(k + (stop_s+1)*T, 0, 1'b0, 1'b0, model_rdy()));
      end else if (rst_p == 0) begin
         msg.delete(); closed = 1'b0;
         exq.push_back(mk(k + (n+N)*T,     0, 1'b0, 1'b1, model_rdy()));
         exq.push_back(mk(k + (n+N)*T + 1, 0, 1'b0, 1'b0, model_rdy()));
      end
      stop_cyc = (stop_s > 0) ? k + (stop_s+1)*T - 1 : -1;
      rst_cyc  = (rst_p > 0) ? k + rst_p*T : -1;
      budget   = (n + N + 4) * T;
      for (int i = 0; i < budget && exq.size() != 0; i++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         bus.stop_i  = (cyc == stop_cyc);
         if (cyc == rst_cyc) begin
            #1 rst_n = 1'b0;
            did_rst = 1'b1;
            exq.delete(); msg.delete(); closed = 1'b0;
            exq.push_back(mk(cyc + 1, 0, 1'b0, 1'b0, 1'b1));
            #1 check_reset_vals("midscroll_reset");
         end
      end
      bus.start_i = 1'b0; bus.stop_i = 1'b0;
      check("scroll_drained", 64'(exq.size()), 64'(0));
      exq.delete();
      if (did_rst) begin
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, s;
      bus.wr_valid_i = 1'b0; bus.wr_code_i = 3'b000; bus.wr_last_i = 1'b0;
      bus.start_i = 1'b0; bus.stop_i = 1'b0;
      #1 rst_n = 1'b0;
      #20;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Start with an empty buffer: the monitor flags any output change.
      @(negedge clk); bus.start_i = 1'b1;
      @(negedge clk); bus.start_i = 1'b0;
      repeat (8) @(negedge clk);
      check("empty_start_busy", 64'(bus.busy_o), 64'(0));

      // Three-symbol message closed by last, full scroll out.
      write_sym(3'b000, 1'b0, 1);
      write_sym(3'b001, 1'b0, 1);
      write_sym(3'b011, 1'b1, 1);
      check("ready_after_last", 64'(bus.wr_ready_o), 64'(0));
      do_scroll(0, 0);

      // Stop at p=2 coinciding with a tick, then replay from the beginning.
      for (int i = 0; i < 5; i++) write_sym(3'($urandom_range(0, 7)), i == 4, 1);
      do_scroll(2, 0);
      do_scroll(0, 0);

      // Fill all 16 entries, then a 17th symbol held valid must not be taken.
      for (int i = 0; i < D; i++) write_sym(3'($urandom_range(0, 7)), 1'b0, 1);
      write_sym(3'b101, 1'b0, 5);
      check("full_count", 64'(msg.size()), 64'(D));
      do_scroll(0, 0);

      // Async reset at p=4, then the three-symbol run again.
      write_sym(3'b000, 1'b0, 1);
      write_sym(3'b001, 1'b0, 1);
      write_sym(3'b011, 1'b1, 1);
      do_scroll(0, 4);
      write_sym(3'b000, 1'b0, 1);
      write_sym(3'b001, 1'b0, 1);
      write_sym(3'b011, 1'b1, 1);
      do_scroll(0, 0);

      // Random messages, random write gaps, occasional stop with replay.
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, D);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            write_sym(3'($urandom_range(0, 7)), (i == n-1) && ($urandom_range(0, 1) == 1), 1);
         end
         if ($urandom_range(0, 2) == 0) begin
            s = $urandom_range(1, n + N - 1);
            do_scroll(s, 0);
         end
         do_scroll(0, 0);
      end

      repeat (3) @(negedge clk);
      check("final_queue_empty", 64'(exq.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
